fpalu_mul_pipe: RTL and testbench

//  Pipelined, parametrised IEEE-754-style FP multiplier; next generation of the FP ALU multiply path.

---
 rtl/fpalu_pkg.sv | 24 ++
 rtl/fpalu_round_norm.sv | 71 +++++++
 rtl/fpalu_mul_pipe.sv | 96 +++++++++
 tb/tb_fpalu_mul_pipe.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/fpalu_pkg.sv
// Shared definitions for the FP ALU datapaths: default formats, operand
// classes, flag bit positions and the canonical quiet-NaN pattern.
package fpalu_pkg;
  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 23;
  localparam int BIAS      = (1 << (DEF_EXP_W - 1)) - 1;
  localparam int FW        = 1 + DEF_EXP_W + DEF_MAN_W;

  typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} fcls_t;

  localparam int FLG_INX = 0;
  localparam int FLG_UNF = 1;
  localparam int FLG_OVF = 2;
  localparam int FLG_INV = 3;

  // {0, all-ones exponent, quiet bit, zeros}, right-aligned in 64 bits
  function automatic logic [63:0] qnan_word(input int exp_w, input int man_w);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < exp_w; i++) w[man_w+i] = 1'b1;
    w[man_w-1] = 1'b1;
    return w;
  endfunction
endpackage

// File: rtl/fpalu_round_norm.sv
// Combinational normalise / round / pack with special-value and exception
// resolution; takes a raw significand product and an unbiased-sum exponent.
module fpalu_round_norm import fpalu_pkg::*; #(
  parameter  int EXP_W = DEF_EXP_W,
  parameter  int MAN_W = DEF_MAN_W,
  localparam int W     = 1 + EXP_W + MAN_W,
  localparam int PW    = 2 * MAN_W + 2,
  localparam int EW    = EXP_W + 2
) (
  input  logic                 sign,
  input  fcls_t                ca,
  input  fcls_t                cb,
  input  logic signed [EW-1:0] esum,
  input  logic [PW-1:0]        prod,
  input  logic                 rnd_mode,
  output logic [W-1:0]         result,
  output logic [3:0]           flags
);
  localparam logic [63:0]          QNAN = qnan_word(EXP_W, MAN_W);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

  logic [PW-2:0]        pn;
  logic signed [EW-1:0] e1, e2;
  logic [MAN_W-1:0]     frac, fr;
  logic                 g, s, inc, carry;
  logic                 is_nan, is_inf, is_zero;

  always_comb begin
    // hidden bit lands at pn's MSB+1 either way; shifted-out bit is always 0
    pn    = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
    e1    = esum + EW'(prod[PW-1]);
    frac  = pn[PW-2 -: MAN_W];
    g     = pn[MAN_W];
    s     = |pn[MAN_W-1:0];
    inc   = !rnd_mode && g && (s || frac[0]);
    {carry, fr} = {1'b0, frac} + {{MAN_W{1'b0}}, inc};
    e2    = e1 + EW'(carry);

    is_nan  = (ca == CLS_NAN) || (cb == CLS_NAN) ||
              (ca == CLS_INF && cb == CLS_ZERO) || (ca == CLS_ZERO && cb == CLS_INF);
    is_inf  = (ca == CLS_INF) || (cb == CLS_INF);
    is_zero = (ca == CLS_ZERO) || (cb == CLS_ZERO);

    result = {sign, e2[EXP_W-1:0], fr};
    flags  = '0;
    flags[FLG_INX] = g | s;
    if (is_nan) begin
      result = QNAN[W-1:0];
      flags  = '0;
      flags[FLG_INV] = 1'b1;
    end else if (is_inf) begin
      result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags  = '0;
    end else if (is_zero) begin
      result = {sign, {(W-1){1'b0}}};
      flags  = '0;
    end else if (e2 >= EMAX) begin
      result = rnd_mode ? {sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                        : {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags  = '0;
      flags[FLG_OVF] = 1'b1;
      flags[FLG_INX] = 1'b1;
    end else if (e2[EW-1] || e2 == '0) begin
      // flush-to-zero; both operands are normal here so the product is nonzero
      result = {sign, {(W-1){1'b0}}};
      flags  = '0;
      flags[FLG_UNF] = 1'b1;
      flags[FLG_INX] = 1'b1;
    end
  end
endmodule

// File: rtl/fpalu_mul_pipe.sv
// Three-stage pipelined FP multiplier: classify/exponent, significand
// product, normalise/round. All stages stall together on output backpressure.
module fpalu_mul_pipe import fpalu_pkg::*; #(
  parameter  int EXP_W = DEF_EXP_W,
  parameter  int MAN_W = DEF_MAN_W,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         rnd_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);
  localparam int STAGES = 3;
  localparam int SW     = MAN_W + 1;
  localparam int PW     = 2 * SW;
  localparam int EW     = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS_S = EW'((1 << (EXP_W - 1)) - 1);

  typedef struct packed {
    logic                 sign;
    fcls_t                ca;
    fcls_t                cb;
    logic signed [EW-1:0] esum;
    logic                 rnd;
  } ctl_t;

  function automatic fcls_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (e == '0) return CLS_ZERO;
    if (&e)      return (f == '0) ? CLS_INF : CLS_NAN;
    return CLS_NORM;
  endfunction

  logic [STAGES:1] vld_pipe;
  logic            adv;
  ctl_t            ctl_d, s1_ctl, s2_ctl;
  logic [SW-1:0]   siga_d, sigb_d, s1_siga, s1_sigb;
  logic [PW-1:0]   s2_prod;
  logic [W-1:0]    rn_result;
  logic [3:0]      rn_flags;

  assign out_valid = vld_pipe[STAGES];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  always_comb begin
    ctl_d      = '0;
    ctl_d.sign = a[W-1] ^ b[W-1];
    ctl_d.ca   = classify(a[W-2:MAN_W], a[MAN_W-1:0]);
    ctl_d.cb   = classify(b[W-2:MAN_W], b[MAN_W-1:0]);
    ctl_d.esum = $signed({2'b00, a[W-2:MAN_W]}) + $signed({2'b00, b[W-2:MAN_W]}) - BIAS_S;
    ctl_d.rnd  = rnd_mode;
    // subnormal fractions flush here; inf/NaN significands are don't-care
    siga_d     = (ctl_d.ca == CLS_NORM) ? {1'b1, a[MAN_W-1:0]} : '0;
    sigb_d     = (ctl_d.cb == CLS_NORM) ? {1'b1, b[MAN_W-1:0]} : '0;
  end

  fpalu_round_norm #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_rn (
    .sign     (s2_ctl.sign),
    .ca       (s2_ctl.ca),
    .cb       (s2_ctl.cb),
    .esum     (s2_ctl.esum),
    .prod     (s2_prod),
    .rnd_mode (s2_ctl.rnd),
    .result   (rn_result),
    .flags    (rn_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_ctl   <= '0;
      s1_siga  <= '0;
      s1_sigb  <= '0;
      s2_ctl   <= '0;
      s2_prod  <= '0;
      result   <= '0;
      flags    <= '0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      s1_ctl   <= ctl_d;
      s1_siga  <= siga_d;
      s1_sigb  <= sigb_d;
      s2_ctl   <= s1_ctl;
      s2_prod  <= s1_siga * s1_sigb;
      result   <= rn_result;
      flags    <= rn_flags;
    end
  end
endmodule

// File: tb/tb_fpalu_mul_pipe.sv
// Directed-vector bench for fpalu_mul_pipe (binary32): single-op table with
// latency checks, a stalled streaming run, and reset with ops in flight.
module tb_fpalu_mul_pipe;
  import fpalu_pkg::*;

  localparam int NV = 22;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        rnd;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, rnd_mode, out_valid, out_ready;
  logic [FW-1:0] a, b, result;
  logic [3:0]    flags;
  vec_t          vt [NV];
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;

  fpalu_mul_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .rnd_mode(rnd_mode), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flags(flags)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_one(input int i);
    int lat;
    @(negedge clk);
    a = vt[i].a; b = vt[i].b; rnd_mode = vt[i].rnd;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("lat[%0d]", i), 32'(lat), 32'd3);
    chk($sformatf("res[%0d]", i), result, vt[i].res);
    chk($sformatf("flg[%0d]", i), 32'(flags), 32'(vt[i].flg));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ii, oo, cnt;
    logic        held_v;
    logic [31:0] held_r;
    logic [3:0]  held_f;

    vt[0]  = '{32'h40000000, 32'h40400000, 1'b0, 32'h40C00000, 4'h0};
    vt[1]  = '{32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40100000, 4'h0};
    vt[2]  = '{32'h3F800001, 32'h3FC00000, 1'b0, 32'h3FC00002, 4'h1};
    vt[3]  = '{32'h3F800001, 32'h3FC00000, 1'b1, 32'h3FC00001, 4'h1};
    vt[4]  = '{32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800000, 4'h5};
    vt[5]  = '{32'h7F000000, 32'h7F000000, 1'b1, 32'h7F7FFFFF, 4'h5};
    vt[6]  = '{32'h00800000, 32'h00800000, 1'b0, 32'h00000000, 4'h3};
    vt[7]  = '{32'h80800000, 32'h00800000, 1'b0, 32'h80000000, 4'h3};
    vt[8]  = '{32'h7F800000, 32'h00000000, 1'b0, 32'h7FC00000, 4'h8};
    vt[9]  = '{32'hFF800000, 32'h40000000, 1'b0, 32'hFF800000, 4'h0};
    vt[10] = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h8};
    vt[11] = '{32'h00000001, 32'h40000000, 1'b0, 32'h00000000, 4'h0};
    vt[12] = '{32'h80000000, 32'h3F800000, 1'b0, 32'h80000000, 4'h0};
    vt[13] = '{32'h3FC00003, 32'h3FAAAAA8, 1'b0, 32'h40000000, 4'h1};
    vt[14] = '{32'h3FC00003, 32'h3FAAAAA8, 1'b1, 32'h3FFFFFFF, 4'h1};
    vt[15] = '{32'h7F000000, 32'h3F800000, 1'b0, 32'h7F000000, 4'h0};
    vt[16] = '{32'h00800000, 32'h3F000000, 1'b0, 32'h00000000, 4'h3};
    vt[17] = '{32'hC0000000, 32'h40400000, 1'b0, 32'hC0C00000, 4'h0};
    vt[18] = '{32'h7F800000, 32'hFF800000, 1'b0, 32'hFF800000, 4'h0};
    vt[19] = '{32'h00800000, 32'h3F800000, 1'b0, 32'h00800000, 4'h0};
    vt[20] = '{32'hFFC00000, 32'h40000000, 1'b0, 32'h7FC00000, 4'h8};
    vt[21] = '{32'h7F000000, 32'h40000000, 1'b0, 32'h7F800000, 4'h5};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; rnd_mode = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_one(i);

    // streaming: 8 back-to-back ops, out_ready toggling 1,0,1,0...
    ii = 0; oo = 0; held_v = 1'b0; held_r = '0; held_f = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      out_ready = (cyc % 2 == 0);
      in_valid  = (ii < 8);
      if (ii < 8) begin
        a = vt[ii].a; b = vt[ii].b; rnd_mode = vt[ii].rnd;
      end
      #1;
      chk("stream_in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (held_v) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_result", result, held_r);
        chk("stall_flags", 32'(flags), 32'(held_f));
      end
      if (oo >= 8) chk("extra_out", 32'(out_valid), 32'd0);
      else if (out_valid) begin
        chk($sformatf("stream_res[%0d]", oo), result, vt[oo].res);
        chk($sformatf("stream_flg[%0d]", oo), 32'(flags), 32'(vt[oo].flg));
        if (out_ready) oo++;
      end
      held_v = out_valid && !out_ready;
      held_r = result;
      held_f = flags;
      if (in_valid && in_ready) ii++;
    end
    in_valid = 1'b0;
    chk("stream_in_count", 32'(ii), 32'd8);
    chk("stream_out_count", 32'(oo), 32'd8);

    // reset with one result stalled at the output and two ops behind it
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = vt[k].a; b = vt[k].b; rnd_mode = vt[k].rnd;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_result", result, 32'h0);
    chk("mid_rst_flags", 32'(flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("post_rst_stale", 32'(cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
